// File: rtl/mem_event_readout_pkg.sv
// Shared definitions for the per-event output-memory readout: default widths,
// reader FSM encoding and the layout of a word held in the skid buffer.
package mem_event_readout_pkg;

    localparam int DEF_DATA_WIDTH = 36;
    localparam int DEF_ADDR_BITS  = 6;
    localparam int DEF_PAGE_BITS  = 1;
    localparam int DEF_CNT_BITS   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // Skid word layout, MSB first: {last, bx[PAGE_BITS-1:0], data[DATA_WIDTH-1:0]}.
    function automatic int skid_width(input int data_w, input int page_bits);
        return data_w + 1 + page_bits;
    endfunction

endpackage

// File: rtl/readout_skid.sv
// Two-entry valid/ready buffer between the 1-clk-latency memory read port and
// the output stream. The head word is held stable until it is accepted.
module readout_skid #(
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             pop;

    assign pop         = (count_q != 2'd0) && out_ready_i;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;
    assign count_o     = count_q;

    // Next-state: a pushed word lands behind whatever survives this cycle's pop.
    always_comb begin
        // NOTE: every signal written here gets its default first, so no path can infer a latch.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({in_valid_i, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = in_data_i;
                else                 tail_d = in_data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = in_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data_i;
                end
            end
            default: ;
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the storage slots are reset too, so the stream data reads 0 out of reset rather than X.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_event_readout.sv
// Reader end of the BX-paged per-event output memories. Each BC0 closes the
// writer's page and streams that page's entries out as valid/ready words.
module mem_event_readout
    import mem_event_readout_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int PAGE_BITS  = DEF_PAGE_BITS,
    parameter int CNT_BITS   = DEF_CNT_BITS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           BC0,
    input  logic [ADDR_BITS:0]             nent,
    output logic                           read_en,
    output logic [PAGE_BITS+ADDR_BITS-1:0] read_add,
    input  logic [DATA_WIDTH-1:0]          mem_data,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic [PAGE_BITS-1:0]           out_bx,
    output logic                           truncated,
    output logic [CNT_BITS-1:0]            event_cnt
);

    localparam int                 SKID_W  = skid_width(DATA_WIDTH, PAGE_BITS);
    localparam logic [ADDR_BITS:0] MAX_ENT = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0] ONE_ENT = {{ADDR_BITS{1'b0}}, 1'b1};

    rd_state_e              state_q, state_d;
    logic [PAGE_BITS-1:0]   wr_page_q, wr_page_d;
    logic [PAGE_BITS-1:0]   rd_page_q, rd_page_d;
    logic [ADDR_BITS:0]     n_rd_q, n_rd_d;
    logic [ADDR_BITS-1:0]   rd_idx_q, rd_idx_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic                   trunc_q, trunc_d;
    logic                   infl_q, infl_d;           // a read whose data is on mem_data now
    logic [PAGE_BITS:0]     infl_tag_q, infl_tag_d;   // {last, bx} of that read
    logic [ADDR_BITS:0]     n_new;
    logic [1:0]             skid_cnt;
    logic                   skid_pop;
    logic [2:0]             room;
    logic                   is_last;
    logic [SKID_W-1:0]      skid_out;

    // Free skid slots after this cycle's pop; the in-flight word already owns one.
    assign skid_pop  = out_valid & out_ready;
    assign room      = 3'd2 - {1'b0, skid_cnt} + {2'b00, skid_pop};
    assign is_last   = ({1'b0, rd_idx_q} == (n_rd_q - ONE_ENT));
    assign read_en   = (state_q == ST_READ) && (room > {2'b00, infl_q});
    assign read_add  = {rd_page_q, rd_idx_q};
    assign n_new     = (nent > MAX_ENT) ? MAX_ENT : nent;

    // Next-state and read issue; BC0 overrides everything and starts the new event.
    always_comb begin
        state_d    = state_q;
        wr_page_d  = wr_page_q;
        rd_page_d  = rd_page_q;
        n_rd_d     = n_rd_q;
        rd_idx_d   = rd_idx_q;
        cnt_d      = cnt_q;
        trunc_d    = trunc_q;
        infl_d     = read_en;
        infl_tag_d = {is_last, rd_page_q};

        case (state_q)
            ST_IDLE: ;
            ST_READ: begin
                if (read_en) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (is_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (skid_cnt == 2'd0 && !infl_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (BC0) begin
            // Any old-event read still unissued after this cycle is lost.
            if (state_q == ST_READ && !(read_en && is_last)) trunc_d = 1'b1;
            rd_page_d = wr_page_q;
            wr_page_d = wr_page_q + 1'b1;
            n_rd_d    = n_new;
            rd_idx_d  = '0;
            cnt_d     = cnt_q + 1'b1;
            state_d   = (n_new != '0) ? ST_READ : ST_IDLE;
        end
    end

    // Reader state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wr_page_q  <= '0;
            rd_page_q  <= '0;
            n_rd_q     <= '0;
            rd_idx_q   <= '0;
            cnt_q      <= '0;
            trunc_q    <= 1'b0;
            infl_q     <= 1'b0;
            infl_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_page_q  <= wr_page_d;
            rd_page_q  <= rd_page_d;
            n_rd_q     <= n_rd_d;
            rd_idx_q   <= rd_idx_d;
            cnt_q      <= cnt_d;
            trunc_q    <= trunc_d;
            infl_q     <= infl_d;
            infl_tag_q <= infl_tag_d;
        end
    end

    readout_skid #(
        .WIDTH(SKID_W)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (infl_q),
        .in_data_i   ({infl_tag_q, mem_data}),
        .out_valid_o (out_valid),
        .out_data_o  (skid_out),
        .out_ready_i (out_ready),
        .count_o     (skid_cnt)
    );

    assign out_data  = skid_out[DATA_WIDTH-1:0];
    assign out_bx    = skid_out[DATA_WIDTH +: PAGE_BITS];
    assign out_last  = skid_out[SKID_W-1];
    assign truncated = trunc_q;
    assign event_cnt = cnt_q;

endmodule
